// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute-stage sequencer around the combinational alu.
// It latches an issued op, holds it on the alu inputs for a fixed number of
// cycles, and then registers the result for writeback. It also owns the
// architectural flag register {N,Z,C,V}.
//
// state | meaning
// IDLE  | no op held, ready to accept
// EXEC  | op held on alu inputs, counting down its path delay
// DONE  | result registered, waiting for writeback to take it
module alu_ex_stage #(
  parameter int DATAW         = 32,
  parameter int FLAGW         = 4,
  parameter int REGW          = 5,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic [DATAW-1:0] in_opA,
  input  logic [DATAW-1:0] in_opB,
  input  logic             in_flagin,
  input  logic [REGW-1:0]  in_wbreg,
  input  logic             flush,
  output logic [3:0]       alu_aluop,
  output logic [DATAW-1:0] alu_opA,
  output logic [DATAW-1:0] alu_opB,
  input  logic [DATAW-1:0] alu_result,
  input  logic [DATAW-1:0] alu_special,
  input  logic [FLAGW-1:0] alu_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_result,
  output logic [DATAW-1:0] out_special,
  output logic             out_special_we,
  output logic [REGW-1:0]  out_wbreg,
  output logic             out_divzero,
  output logic [FLAGW-1:0] flag_q,
  output logic             busy
);

  // Opcode encoding shared with the alu; only the multicycle group matters here.
  localparam logic [3:0] ALUOP_MUL  = 4'h8;
  localparam logic [3:0] ALUOP_MULU = 4'h9;
  localparam logic [3:0] ALUOP_DIV  = 4'hA;
  localparam logic [3:0] ALUOP_DIVU = 4'hB;

  // Countdown load for mul/div: capture happens MULDIV_CYCLES edges after accept.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  // Flags forced on divide by zero: N=1, Z=0, C=0, V=1.
  localparam logic [FLAGW-1:0] DIVZERO_FLAGS = FLAGW'(4'b1001);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            flagin_q;
  logic [REGW-1:0] wbreg_q;

  logic in_is_muldiv;
  logic held_is_muldiv;
  logic held_divzero;
  logic accept;

  assign in_is_muldiv   = (in_aluop == ALUOP_MUL) || (in_aluop == ALUOP_MULU) ||
                          (in_aluop == ALUOP_DIV) || (in_aluop == ALUOP_DIVU);
  assign held_is_muldiv = (alu_aluop == ALUOP_MUL) || (alu_aluop == ALUOP_MULU) ||
                          (alu_aluop == ALUOP_DIV) || (alu_aluop == ALUOP_DIVU);
  assign held_divzero   = ((alu_aluop == ALUOP_DIV) || (alu_aluop == ALUOP_DIVU)) &&
                          (alu_opB == '0);

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state != IDLE);

  // Sequencer: flush first, then capture/handshake, then accept of a new op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      flagin_q       <= 1'b0;
      wbreg_q        <= '0;
      alu_aluop      <= '0;
      alu_opA        <= '0;
      alu_opB        <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_special    <= '0;
      out_special_we <= 1'b0;
      out_wbreg      <= '0;
      out_divzero    <= 1'b0;
      flag_q         <= '0;
    end else if (flush) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_special_we <= 1'b0;
      out_divzero    <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_result     <= held_divzero ? '1 : alu_result;
            out_special    <= held_divzero ? alu_opA : alu_special;
            out_special_we <= held_is_muldiv;
            out_divzero    <= held_divzero;
            out_wbreg      <= wbreg_q;
            out_valid      <= 1'b1;
            if (flagin_q)
              flag_q <= held_divzero ? DIVZERO_FLAGS : alu_flag;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            out_special_we <= 1'b0;
            out_divzero    <= 1'b0;
            state          <= IDLE;
          end
        end
        default: ;
      endcase

      // A new op overrides the IDLE/DONE next-state decided above.
      if (accept) begin
        alu_aluop <= in_aluop;
        alu_opA   <= in_opA;
        alu_opB   <= in_opB;
        flagin_q  <= in_flagin;
        wbreg_q   <= in_wbreg;
        cnt       <= in_is_muldiv ? MD_LOAD : 4'd0;
        state     <= EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: bench for alu_ex_stage with a behavioural alu attached.
module tb_alu_ex_stage;
  localparam int DATAW = 32;
  localparam int FLAGW = 4;
  localparam int REGW  = 5;
  localparam int MDC   = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_MULU = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_aluop;
  logic [DATAW-1:0] in_opA;
  logic [DATAW-1:0] in_opB;
  logic             in_flagin;
  logic [REGW-1:0]  in_wbreg;
  logic             flush;
  logic [3:0]       alu_aluop;
  logic [DATAW-1:0] alu_opA;
  logic [DATAW-1:0] alu_opB;
  logic [DATAW-1:0] alu_result;
  logic [DATAW-1:0] alu_special;
  logic [FLAGW-1:0] alu_flag;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_result;
  logic [DATAW-1:0] out_special;
  logic             out_special_we;
  logic [REGW-1:0]  out_wbreg;
  logic             out_divzero;
  logic [FLAGW-1:0] flag_q;
  logic             busy;

  alu_ex_stage #(
    .DATAW(DATAW), .FLAGW(FLAGW), .REGW(REGW), .MULDIV_CYCLES(MDC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_opA(in_opA), .in_opB(in_opB), .in_flagin(in_flagin), .in_wbreg(in_wbreg),
    .flush(flush),
    .alu_aluop(alu_aluop), .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_result(alu_result), .alu_special(alu_special), .alu_flag(alu_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_special(out_special), .out_special_we(out_special_we),
    .out_wbreg(out_wbreg), .out_divzero(out_divzero),
    .flag_q(flag_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  // Edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] spec;
    logic [3:0]  flg;
  } alu_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] spec;
    logic        we;
    logic        dz;
    logic [4:0]  wbreg;
    logic        flagin;
    logic [3:0]  flg;
    logic [7:0]  lat;
  } exp_t;

  // Behavioural alu, flags {N,Z,C,V}; C is carry for add and borrow for sub.
  function automatic alu_t alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_t r;
    logic [32:0] w;
    logic [63:0] p;
    r = '0;
    w = '0;
    p = '0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r.res = w[31:0];
        r.flg[1] = w[32];
        r.flg[0] = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      OP_SUB: begin
        r.res = a - b;
        r.flg[1] = (a < b);
        r.flg[0] = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_MUL: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.res = p[31:0];
        r.spec = p[63:32];
      end
      OP_MULU: begin
        p = {32'b0, a} * {32'b0, b};
        r.res = p[31:0];
        r.spec = p[63:32];
      end
      OP_DIV: if (b != 0) begin
        r.res  = $signed(a) / $signed(b);
        r.spec = $signed(a) % $signed(b);
      end
      OP_DIVU: if (b != 0) begin
        r.res  = a / b;
        r.spec = a % b;
      end
      default: ;
    endcase
    r.flg[3] = r.res[31];
    r.flg[2] = (r.res == 32'd0);
    return r;
  endfunction

  alu_t alu_m;
  assign alu_m       = alu_f(alu_aluop, alu_opA, alu_opB);
  assign alu_result  = alu_m.res;
  assign alu_special = alu_m.spec;
  assign alu_flag    = alu_m.flg;

  exp_t        sb[$];
  exp_t        ex;
  logic [3:0]  model_flag;
  int          acc_cyc;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] o_result, o_special;
  logic        o_we, o_dz, o_to;
  logic [4:0]  o_wbreg;
  int          o_lat;

  // Drive an op from the current point; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fi, input logic [4:0] wb);
    exp_t e;
    alu_t m;
    int n;
    m = alu_f(op, a, b);
    e.res = m.res;
    e.spec = m.spec;
    e.flg = m.flg;
    e.we = (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
    e.dz = 1'b0;
    if (((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0)) begin
      e.res = 32'hFFFFFFFF;
      e.spec = a;
      e.dz = 1'b1;
      e.flg = 4'b1001;
    end
    e.wbreg = wb;
    e.flagin = fi;
    e.lat = e.we ? 8'(MDC) : 8'd1;
    in_aluop = op;
    in_opA = a;
    in_opB = b;
    in_flagin = fi;
    in_wbreg = wb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
        $fatal(1, "issue timed out");
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Wait for out_valid, sample outputs, pop the matching expectation.
  task automatic collect();
    int n;
    o_to = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) o_to = 1'b1;
    o_lat = cyc - acc_cyc;
    o_result = out_result;
    o_special = out_special;
    o_we = out_special_we;
    o_dz = out_divzero;
    o_wbreg = out_wbreg;
    if (sb.size() > 0) ex = sb.pop_front();
    else ex = '0;
    if (ex.flagin) model_flag = ex.flg;
    if (out_ready && !o_to) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_aluop = '0; in_opA = '0; in_opB = '0;
    in_flagin = 1'b0; in_wbreg = '0; flush = 1'b0; out_ready = 1'b1;
    model_flag = 4'b0000;
    #23;
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++;
      $display("FAIL reset_ctrl: {out_valid,in_ready,busy}=%b required 010", {out_valid, in_ready, busy}); end
    n_cmp++; if (flag_q !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flag: flag_q=%b required 0000", flag_q); end
    n_cmp++; if ({out_result, out_special, alu_opA, alu_opB, alu_aluop} !== '0) begin n_fail++;
      $display("FAIL reset_data: result=%h special=%h opA=%h opB=%h required 0", out_result, out_special, alu_opA, alu_opB); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(OP_ADD, 32'd7, 32'd5, 1'b1, 5'd3);
    collect();
    n_cmp++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL add_timeout: out_valid never rose"); end
    n_cmp++; if (o_lat !== int'(ex.lat)) begin n_fail++; $display("FAIL add_latency: got %0d required %0d", o_lat, ex.lat); end
    n_cmp++; if (o_result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h required %h", o_result, 32'd12); end
    n_cmp++; if ({o_we, o_dz, o_wbreg} !== {ex.we, ex.dz, ex.wbreg}) begin n_fail++;
      $display("FAIL add_side: we/dz/wbreg got %b/%b/%0d required %b/%b/%0d", o_we, o_dz, o_wbreg, ex.we, ex.dz, ex.wbreg); end
    n_cmp++; if (flag_q !== 4'b0000) begin n_fail++; $display("FAIL add_flags: flag_q=%b required 0000", flag_q); end
  endtask

  task automatic test_muldiv();
    issue(OP_MUL, 32'hFFFFFFFD, 32'd4, 1'b1, 5'd7);
    collect();
    n_cmp++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL mul_timeout: out_valid never rose"); end
    n_cmp++; if (o_lat !== MDC) begin n_fail++; $display("FAIL mul_latency: got %0d required %0d", o_lat, MDC); end
    n_cmp++; if ({o_result, o_special} !== {32'hFFFFFFF4, 32'hFFFFFFFF}) begin n_fail++;
      $display("FAIL mul_data: result=%h special=%h required FFFFFFF4 FFFFFFFF", o_result, o_special); end
    n_cmp++; if ({o_we, o_dz, o_wbreg} !== {1'b1, 1'b0, 5'd7}) begin n_fail++;
      $display("FAIL mul_side: we/dz/wbreg got %b/%b/%0d required 1/0/7", o_we, o_dz, o_wbreg); end
    n_cmp++; if (flag_q !== model_flag) begin n_fail++; $display("FAIL mul_flags: flag_q=%b required %b", flag_q, model_flag); end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 5'd9);
    collect();
    n_cmp++; if (o_lat !== MDC) begin n_fail++; $display("FAIL div_latency: got %0d required %0d", o_lat, MDC); end
    n_cmp++; if ({o_result, o_special, o_dz} !== {ex.res, ex.spec, 1'b0}) begin n_fail++;
      $display("FAIL div_data: result=%h special=%h dz=%b required %h %h 0", o_result, o_special, o_dz, ex.res, ex.spec); end
    n_cmp++; if (out_special_we !== 1'b0) begin n_fail++; $display("FAIL we_cleared: out_special_we=%b required 0 when idle", out_special_we); end
  endtask

  task automatic test_divzero();
    issue(OP_DIVU, 32'd9, 32'd0, 1'b1, 5'd2);
    collect();
    n_cmp++; if (o_lat !== MDC) begin n_fail++; $display("FAIL dz_latency: got %0d required %0d", o_lat, MDC); end
    n_cmp++; if ({o_result, o_special} !== {32'hFFFFFFFF, 32'd9}) begin n_fail++;
      $display("FAIL dz_data: result=%h special=%h required FFFFFFFF 00000009", o_result, o_special); end
    n_cmp++; if ({o_dz, o_we} !== 2'b11) begin n_fail++; $display("FAIL dz_bits: dz/we=%b required 11", {o_dz, o_we}); end
    n_cmp++; if (flag_q !== 4'b1001) begin n_fail++; $display("FAIL dz_flags: flag_q=%b required 1001", flag_q); end
    n_cmp++; if (out_divzero !== 1'b0) begin n_fail++; $display("FAIL dz_cleared: out_divzero=%b required 0 when idle", out_divzero); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    issue(OP_SUB, 32'd5, 32'd5, 1'b1, 5'd4);
    collect();
    n_cmp++; if (flag_q !== 4'b0100) begin n_fail++; $display("FAIL sub_flags: flag_q=%b required 0100", flag_q); end
    out_ready = 1'b0;
    issue(OP_AND, 32'h0000FF00, 32'h00008F00, 1'b0, 5'd6);
    collect();
    held = o_result;
    n_cmp++; if (o_result !== 32'h00008F00) begin n_fail++; $display("FAIL and_result: got %h required 00008F00", o_result); end
    n_cmp++; if (flag_q !== model_flag) begin n_fail++; $display("FAIL and_flags_hold: flag_q=%b required %b", flag_q, model_flag); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, out_result, out_wbreg} !== {1'b1, 1'b0, held, 5'd6}) begin n_fail++;
        $display("FAIL stall_hold%0d: valid=%b in_ready=%b result=%h wbreg=%0d required 1 0 %h 6", i, out_valid, in_ready, out_result, out_wbreg, held); end
    end
    out_ready = 1'b1;
    issue(OP_ADD, 32'd1, 32'd2, 1'b0, 5'd8);
    n_cmp++; if ({out_valid, busy} !== 2'b01) begin n_fail++;
      $display("FAIL b2b_accept: valid/busy=%b required 01", {out_valid, busy}); end
    collect();
    n_cmp++; if ({o_to, o_lat, o_result} !== {1'b0, 1, 32'd3}) begin n_fail++;
      $display("FAIL b2b_result: to=%b lat=%0d result=%h required 0 1 00000003", o_to, o_lat, o_result); end
    n_cmp++; if (flag_q !== 4'b0100) begin n_fail++; $display("FAIL b2b_flags: flag_q=%b required 0100", flag_q); end
  endtask

  task automatic test_flush();
    logic seen;
    issue(OP_MUL, 32'd7, 32'd3, 1'b1, 5'd10);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++;
      $display("FAIL flush_ctrl: {out_valid,in_ready,busy}=%b required 010", {out_valid, in_ready, busy}); end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_valid: out_valid rose after flush"); end
    n_cmp++; if (flag_q !== model_flag) begin n_fail++; $display("FAIL flush_flags: flag_q=%b required %b", flag_q, model_flag); end
  endtask

  task automatic test_reset_mid();
    issue(OP_MULU, 32'd5, 32'd6, 1'b1, 5'd11);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, busy, flag_q, in_ready} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin n_fail++;
      $display("FAIL midreset_ctrl: valid=%b busy=%b flag_q=%b in_ready=%b required 0 0 0000 1", out_valid, busy, flag_q, in_ready); end
    n_cmp++; if ({alu_opA, alu_opB, alu_aluop} !== '0) begin n_fail++;
      $display("FAIL midreset_alu: opA=%h opB=%h op=%h required 0", alu_opA, alu_opB, alu_aluop); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    model_flag = 4'b0000;
    @(negedge clk);
    issue(OP_ADD, 32'd1, 32'd1, 1'b1, 5'd1);
    collect();
    n_cmp++; if ({o_to, o_lat, o_result, flag_q} !== {1'b0, 1, 32'd2, model_flag}) begin n_fail++;
      $display("FAIL post_reset_add: to=%b lat=%0d result=%h flag_q=%b required 0 1 00000002 %b", o_to, o_lat, o_result, flag_q, model_flag); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_muldiv();
    test_divzero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
